fetch_unit: RTL and testbench

Instruction fetch stage of the single-issue CPU, sitting directly upstream of the instruction decoder/control block. Holds the program counter and drives a synchronous-read instruction memory. Buffers returned words in a 2-entry queue and presents them to the decoder over a valid/ready handshake with their PC. Supports a redirect input (branch/jump target) that flushes all buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 88 ++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, synchronous imem request, 2-entry
// instruction queue with valid/ready handshake toward the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        inflight;
    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic        head;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        wr_idx;
    logic [2:0]  occ;

    assign instr_valid = (count != 2'd0);
    assign instr       = q_instr[head];
    assign instr_pc    = q_pc[head];

    assign pop    = instr_valid && instr_ready;
    assign push   = inflight && !redirect_valid;
    assign occ    = {1'b0, count} + {2'b00, inflight};
    // At count 2 the tail slot is the head slot being popped.
    assign wr_idx = head ^ count[0];

    assign imem_req  = !rst && !redirect_valid &&
                       (occ < (3'd2 + {2'b00, pop}));
    assign imem_addr = fetch_pc[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            head        <= 1'b0;
            count       <= 2'd0;
            q_instr[0]  <= 32'h0;
            q_instr[1]  <= 32'h0;
            q_pc[0]     <= 32'h0;
            q_pc[1]     <= 32'h0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            count    <= 2'd0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
            if (push) begin
                q_instr[wr_idx] <= imem_rdata;
                q_pc[wr_idx]    <= inflight_pc;
            end
            if (pop) begin
                head <= !head;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count == 2'd2 && !pop))
                else $error("fetch queue overflow");
            assert (count != 2'd3)
                else $error("fetch queue count out of range");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a model PC predicts each request and
// queues the expected {pc, instr}; deliveries pop and compare.
module tb_fetch_unit;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic [31:0]   instr;
    logic [31:0]   instr_pc;
    logic          instr_valid;
    logic          instr_ready;

    logic          w_req;
    logic [AW-1:0] w_addr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_instr;
    logic [31:0]   w_pc;
    logic          w_valid;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(AW)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr          (w_instr),
        .instr_pc       (w_pc),
        .instr_valid    (w_valid),
        .instr_ready    (1'b1)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h0010_0093 + {{(32-AW){1'b0}}, a};
    endfunction

    always_ff @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
        if (w_req)    w_rdata    <= mem_word(w_addr);
    end

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    int unsigned  n_deliv  = 0;
    int unsigned  n_req    = 0;
    logic [31:0]  exp_pc   = 32'h0;
    logic [63:0]  sb_q[$];

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic sb_step();
        logic [63:0] e;
        if (rst) begin
            check("req_in_rst", 32'(imem_req), 32'h0);
            sb_q.delete();
            exp_pc = 32'h0;
        end else if (redirect_valid) begin
            check("req_in_redir", 32'(imem_req), 32'h0);
            sb_q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'(sb_q.size()), 32'h1);
                end else begin
                    e = sb_q.pop_front();
                    check("deliv_pc", instr_pc, e[63:32]);
                    check("deliv_instr", instr, e[31:0]);
                end
                n_deliv++;
            end
            if (imem_req) begin
                check("req_addr", 32'(imem_addr),
                      32'(exp_pc[AW+1:2]));
                sb_q.push_back({exp_pc, mem_word(exp_pc[AW+1:2])});
                exp_pc = exp_pc + 32'd4;
                n_req++;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst            = r;
        instr_ready    = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        sb_step();
    endtask

    int unsigned d0;
    int unsigned r0;

    initial begin
        rst            = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // reset state
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);

        // streaming with ready high; wrap instance runs alongside
        d0 = n_deliv;
        for (int c = 0; c < 10; c++) begin
            cyc(0, 1, 0, 0);
            if (c == 0) begin
                check("c0_req", 32'(imem_req), 32'h1);
                check("c0_addr", 32'(imem_addr), 32'h0);
            end
            if (c == 1) check("c1_valid", 32'(instr_valid), 32'h0);
            if (c >= 2) begin
                check("stream_valid", 32'(instr_valid), 32'h1);
                check("stream_pc", instr_pc, 32'((c - 2) * 4));
            end
            if (c == 2) begin
                check("wrap_pc0", w_pc, 32'hFFFF_FFF8);
                check("wrap_in0", w_instr, 32'h0010_0491);
            end
            if (c == 3) begin
                check("wrap_pc1", w_pc, 32'hFFFF_FFFC);
                check("wrap_in1", w_instr, 32'h0010_0492);
            end
            if (c == 4) begin
                check("wrap_pc2", w_pc, 32'h0000_0000);
                check("wrap_in2", w_instr, 32'h0010_0093);
            end
        end
        check("stream_count", n_deliv - d0, 32'd8);

        // back-pressure
        cyc(1, 0, 0, 0);
        r0 = n_req;
        for (int c = 0; c < 10; c++) begin
            cyc(0, 0, 0, 0);
            if (c >= 2) check("bp_noreq", 32'(imem_req), 32'h0);
            if (c == 5 || c == 9) begin
                check("bp_valid", 32'(instr_valid), 32'h1);
                check("bp_pc", instr_pc, 32'h0);
                check("bp_instr", instr, 32'h0010_0093);
            end
        end
        check("bp_nreq", n_req - r0, 32'd2);
        for (int c = 0; c < 5; c++) begin
            cyc(0, 1, 0, 0);
            check("bp_rel_valid", 32'(instr_valid), 32'h1);
            check("bp_rel_pc", instr_pc, 32'(c * 4));
        end

        // redirect with one word queued and one in flight
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h0000_0103);
        cyc(0, 0, 0, 0);
        check("rd_req", 32'(imem_req), 32'h1);
        check("rd_addr", 32'(imem_addr), 32'h40);
        cyc(0, 0, 0, 0);
        check("rd_gap", 32'(instr_valid), 32'h0);
        cyc(0, 0, 0, 0);
        check("rd_valid", 32'(instr_valid), 32'h1);
        check("rd_pc", instr_pc, 32'h0000_0100);
        check("rd_instr", instr, 32'h0010_00D3);

        // redirect coincident with a handshake, held two cycles
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h0000_01F0);
        check("hs_pre_valid", 32'(instr_valid), 32'h1);
        d0 = n_deliv;
        cyc(0, 1, 1, 32'h0000_0200);
        cyc(0, 1, 0, 0);
        check("hs_addr", 32'(imem_addr), 32'h80);
        cyc(0, 1, 0, 0);
        check("hs_gap", 32'(instr_valid), 32'h0);
        cyc(0, 1, 0, 0);
        check("hs_valid", 32'(instr_valid), 32'h1);
        check("hs_pc", instr_pc, 32'h0000_0200);
        check("hs_ndeliv", n_deliv - d0, 32'd1);
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 0);

        // reset mid-stream with the queue full
        cyc(1, 0, 0, 0);
        for (int c = 0; c < 4; c++) cyc(0, 0, 0, 0);
        check("mr_full", 32'(instr_valid), 32'h1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("mr_valid", 32'(instr_valid), 32'h0);
        check("mr_req", 32'(imem_req), 32'h0);
        cyc(0, 1, 0, 0);
        check("mr_addr", 32'(imem_addr), 32'h0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        check("mr_pc", instr_pc, 32'h0);
        check("mr_v", 32'(instr_valid), 32'h1);
        for (int c = 0; c < 3; c++) cyc(0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
